// File: rtl/car_sensor_gen_pkg.sv
// car_gen_pkg: shared state enum, direction codes and {a,b} sensor patterns for car_sensor_gen (reverse states need CAR_GEN_ABORT_EN)
package car_gen_pkg;
`ifdef CAR_GEN_ABORT_EN
  typedef enum logic [2:0] {IDLE, S_FIRST, S_BOTH, S_SECOND, GAP, R_BOTH, R_FIRST} state_t;
`else
  typedef enum logic [2:0] {IDLE, S_FIRST, S_BOTH, S_SECOND, GAP} state_t;
`endif
  localparam logic DIR_ENTER = 1'b0;
  localparam logic DIR_EXIT = 1'b1;
  localparam logic [1:0] PAT_NONE = 2'b00;
  localparam logic [1:0] PAT_A = 2'b10;
  localparam logic [1:0] PAT_B = 2'b01;
  localparam logic [1:0] PAT_AB = 2'b11;
  function automatic logic [1:0] sensor_pat(input state_t s, input logic d);
    logic [1:0] f;
    f = (d == DIR_ENTER) ? PAT_A : PAT_B;
    case (s)
      S_FIRST: return f;
      S_BOTH: return PAT_AB;
      S_SECOND: return (f == PAT_A) ? PAT_B : PAT_A;
`ifdef CAR_GEN_ABORT_EN
      R_BOTH: return PAT_AB;
      R_FIRST: return f;
`endif
      default: return PAT_NONE;
    endcase
  endfunction
endpackage

// File: rtl/car_sensor_gen_phase_timer.sv
// phase_timer: PHASE_W-bit phase down-counter (clk, reset, load, len -> expire); zero-length loads count as one cycle
module phase_timer #(
  parameter int PHASE_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [PHASE_W-1:0] len,
  output logic               expire
);
  logic [PHASE_W-1:0] r_cnt;
  always_ff @(posedge clk)
    r_cnt <= reset ? '0 :
             load ? ((len == '0) ? '0 : len - PHASE_W'(1)) :
             (r_cnt != '0) ? r_cnt - PHASE_W'(1) : r_cnt;
  assign expire = (r_cnt == '0);
endmodule

// File: rtl/car_sensor_gen.sv
// car_sensor_gen: emulates a car passing sensors a/b (clk, reset, start, dir, len -> ready, a, b, done; abort -> aborted when CAR_GEN_ABORT_EN)
module car_sensor_gen
  import car_gen_pkg::*;
#(
  parameter int PHASE_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               dir,
  input  logic [PHASE_W-1:0] len,
`ifdef CAR_GEN_ABORT_EN
  input  logic               abort,
  output logic               aborted,
`endif
  output logic               ready,
  output logic               a,
  output logic               b,
  output logic               done
);
  state_t r_state, w_next;
  logic r_dir;
  logic [PHASE_W-1:0] r_len, w_tlen;
  logic w_exp, w_load, w_accept, w_gap_in, w_was_abt;
  logic [1:0] w_pat;
`ifdef CAR_GEN_ABORT_EN
  logic r_abt, w_abt;
  assign w_abt = abort && (r_state == S_FIRST || r_state == S_BOTH || r_state == S_SECOND);
  assign w_was_abt = r_abt || w_abt;
`else
  assign w_was_abt = 1'b0;
`endif
  assign w_accept = (r_state == IDLE) && start;
  assign ready = (r_state == IDLE);
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: w_next = start ? S_FIRST : IDLE;
      S_FIRST: w_next = w_exp ? S_BOTH : S_FIRST;
      S_BOTH: w_next = w_exp ? S_SECOND : S_BOTH;
      S_SECOND: w_next = w_exp ? GAP : S_SECOND;
      GAP: w_next = w_exp ? IDLE : GAP;
`ifdef CAR_GEN_ABORT_EN
      R_BOTH: w_next = w_exp ? R_FIRST : R_BOTH;
      R_FIRST: w_next = w_exp ? GAP : R_FIRST;
`endif
      default: w_next = IDLE;
    endcase
`ifdef CAR_GEN_ABORT_EN
    if (w_abt) w_next = (r_state == S_FIRST) ? GAP : (r_state == S_BOTH) ? R_FIRST : R_BOTH;
`endif
  end
  assign w_load = (w_next != r_state);
  assign w_tlen = (r_state == IDLE) ? len : r_len;
  assign w_pat = sensor_pat(w_next, (r_state == IDLE) ? dir : r_dir);
  assign w_gap_in = (w_next == GAP) && (r_state != GAP);
  phase_timer #(.PHASE_W(PHASE_W)) u_timer (
    .clk(clk),
    .reset(reset),
    .load(w_load),
    .len(w_tlen),
    .expire(w_exp)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      {a, b} <= PAT_NONE;
      done <= 1'b0;
      r_dir <= 1'b0;
      r_len <= '0;
    end else begin
      r_state <= w_next;
      {a, b} <= w_pat;
      done <= w_gap_in && !w_was_abt;
      if (w_accept) begin
        r_dir <= dir;
        r_len <= len;
      end
    end
  end
`ifdef CAR_GEN_ABORT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      r_abt <= 1'b0;
      aborted <= 1'b0;
    end else begin
      r_abt <= w_accept ? 1'b0 : w_was_abt;
      aborted <= w_gap_in && w_was_abt;
    end
  end
`endif
endmodule

// File: tb/tb_car_sensor_gen.sv
// tb_car_sensor_gen: randomized + directed bench for car_sensor_gen against a pass-schedule queue model and a behavioural decoder
module tb_car_sensor_gen;
  localparam int W = 8;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, dir = 1'b0;
  logic [W-1:0] len = '0;
  logic ready, a, b, done;
`ifdef CAR_GEN_ABORT_EN
  logic abort = 1'b0, aborted;
`endif
  always #5 clk = ~clk;
  car_sensor_gen #(.PHASE_W(W)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .dir(dir),
    .len(len),
`ifdef CAR_GEN_ABORT_EN
    .abort(abort),
    .aborted(aborted),
`endif
    .ready(ready),
    .a(a),
    .b(b),
    .done(done)
  );
  typedef struct packed {logic a; logic b; logic done; logic ab;} exp_t;
  exp_t q[$];
  logic [1:0] hist[$];
  logic [1:0] last_pat = 2'b00;
  logic m_dir = 1'b0;
  int n_cmp = 0, n_bad = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step(input logic s, input logic d, input int l, input logic r);
    logic [1:0] f, p;
    exp_t e;
    int dec, nl;
    start = s;
    dir = d;
    len = W'(l);
    reset = r;
    @(posedge clk);
    if (r) q.delete();
    else if (q.size() != 0) void'(q.pop_front());
    else if (s) begin
      nl = (l == 0) ? 1 : l;
      m_dir = d;
      f = d ? 2'b01 : 2'b10;
      for (int i = 0; i < nl; i++) q.push_back({f, 2'b00});
      for (int i = 0; i < nl; i++) q.push_back({2'b11, 2'b00});
      for (int i = 0; i < nl; i++) q.push_back({~f, 2'b00});
      for (int i = 0; i < nl; i++) q.push_back({2'b00, (i == 0), 1'b0});
    end
    #1;
    e = (q.size() != 0) ? q[0] : exp_t'(4'b0000);
    check("a", a, e.a);
    check("b", b, e.b);
    check("done", done, e.done);
    check("ready", ready, q.size() == 0);
`ifdef CAR_GEN_ABORT_EN
    check("aborted", aborted, e.ab);
`endif
    p = {a, b};
    dec = 0;
    if (r) begin
      hist.delete();
      last_pat = 2'b00;
    end else if (p != last_pat) begin
      if (p == 2'b00) begin
        if (hist.size() == 3 && hist[0] == 2'b10 && hist[1] == 2'b11 && hist[2] == 2'b01) dec = 1;
        else if (hist.size() == 3 && hist[0] == 2'b01 && hist[1] == 2'b11 && hist[2] == 2'b10) dec = 2;
        hist.delete();
      end else hist.push_back(p);
      last_pat = p;
    end
    if (done || dec != 0) check("decoder", dec, done ? (m_dir ? 2 : 1) : 0);
    @(negedge clk);
  endtask
  initial begin
    @(negedge clk);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    step(1, 0, 3, 0);
    repeat (13) step(0, 1, 7, 0);
    step(1, 1, 0, 0);
    repeat (5) step(0, 0, 0, 0);
    step(1, 0, 2, 0);
    repeat (8) step(0, 0, 0, 0);
    step(1, 1, 2, 0);
    repeat (8) step(0, 0, 0, 0);
    repeat (14) step(1, 0, 1, 0);
    step(0, 0, 0, 0);
    step(1, 0, 4, 0);
    repeat (5) step(0, 0, 4, 0);
    step(1, 0, 4, 1);
    repeat (6) step(0, 0, 0, 0);
`ifdef CAR_GEN_ABORT_EN
    step(1, 0, 2, 0);
    repeat (4) step(0, 0, 2, 0);
    q.delete();
    q.push_back({2'b01, 2'b00});
    q.push_back({2'b11, 2'b00});
    q.push_back({2'b11, 2'b00});
    q.push_back({2'b10, 2'b00});
    q.push_back({2'b10, 2'b00});
    q.push_back({2'b00, 2'b01});
    q.push_back({2'b00, 2'b00});
    abort = 1'b1;
    step(0, 0, 2, 0);
    abort = 1'b0;
    repeat (8) step(0, 0, 0, 0);
`endif
    for (int i = 0; i < 3000; i++)
      step($urandom_range(2) == 0, 1'($urandom_range(1)), $urandom_range(3), $urandom_range(99) == 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/car_sensor_gen.md
CAR_SENSOR_GEN -- requirements
Module: car_sensor_gen

Interface
REQ-001 The block SHALL have one parameter: PHASE_W, default 8, width of the per-phase duration field.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: start  input  1  pass request; accepted on an edge where start&&ready.
REQ-006 Port: dir  input  1  direction, latched on accept: 0 = entry (a first), 1 = exit (b first).
REQ-007 Port: len  input  PHASE_W  phase duration in cycles, latched on accept; 0 is treated as 1.
REQ-008 Port: ready  output  1  idle and able to accept start.
REQ-009 Port: a  output  1  emulated outer sensor, registered.
REQ-010 Port: b  output  1  emulated inner sensor, registered.
REQ-011 Port: done  output  1  one-cycle pulse marking a completed pass.

Function
REQ-012 The states SHALL be IDLE, S_FIRST, S_BOTH, S_SECOND and GAP.
- entry: S_FIRST drives a=1,b=0; S_SECOND drives a=0,b=1.
- exit: S_FIRST drives a=0,b=1; S_SECOND drives a=1,b=0.
- S_BOTH drives a=b=1; IDLE and GAP drive a=b=0.
REQ-013 On an accept edge the block SHALL enter S_FIRST, so the first sensor is high in the first cycle after the accept edge.
REQ-014 Each of S_FIRST, S_BOTH, S_SECOND and GAP SHALL last exactly max(len,1) cycles, then advance in that order; GAP returns to IDLE.
REQ-015 The phase counter SHALL reload on every state change and count down to zero; there SHALL be no wrap-around.
REQ-016 done SHALL pulse high for exactly the first GAP cycle, aligned with the decoder's enter/exit pulse.
REQ-017 ready SHALL be 1 only in IDLE, so a pass occupies 4*max(len,1) cycles from the first sensor to ready.
REQ-018 start while ready=0 SHALL be ignored and SHALL NOT be queued; dir and len changes mid-pass SHALL have no effect.
REQ-019 a and b SHALL never change together on one edge, except S_BOTH to S_SECOND and S_FIRST to GAP (abort), which are single transitions by construction.

Reset
REQ-020 When reset is sampled high at an edge, the outputs after that edge SHALL be: state=IDLE, a=0, b=0, done=0, ready=1, counter=0, latched dir/len=0, and aborted=0 when it exists.
REQ-021 Reset SHALL take priority over start and abort, including in the middle of a pass; no done pulse SHALL be emitted for a pass cut short by reset.

Configuration
REQ-022 Macro CAR_GEN_ABORT_EN, when defined, SHALL add the following ports and states:
- Port abort  input  1.
- Port aborted  output  1, a one-cycle pulse.
- States R_BOTH and R_FIRST (car backs out).
REQ-023 With CAR_GEN_ABORT_EN defined, abort sampled high in a forward state SHALL cause the following transitions:
- S_FIRST -> GAP.
- S_BOTH -> R_FIRST -> GAP.
- S_SECOND -> R_BOTH -> R_FIRST -> GAP.
- R_BOTH drives a=b=1; R_FIRST drives the first sensor only.
- Each reverse phase lasts max(len,1) cycles.
- On an aborted pass, the first GAP cycle SHALL pulse aborted instead of done.
- abort in IDLE, GAP or a reverse state SHALL be ignored.
- abort on the accept edge SHALL be ignored.
REQ-024 Without CAR_GEN_ABORT_EN, the abort/aborted ports and the reverse states SHALL be absent, and behaviour SHALL be per REQ-012..019.

Structure
REQ-025 Package car_gen_pkg SHALL hold:
- the state enum;
- DIR_ENTER=1'b0 and DIR_EXIT=1'b1;
- the sensor-pattern encoding constants.
REQ-026 Sub-module phase_timer SHALL provide the PHASE_W-bit down-counter: inputs load and len, output expire; zero-length loads are clamped to 1.

Verification
REQ-027 Entry, len=3, start for one cycle: a=1,b=0 for 3 cycles; then a=b=1 for 3; then a=0,b=1 for 3; done high in the cycle after; ready rises 12 cycles after the first a=1.
REQ-028 Exit, len=0: b-only 1 cycle, both 1, a-only 1, GAP 1 with done=1; ready returns after 4 cycles.
REQ-029 Loopback into the parking-lot sensor decoder, entry then exit with len=2: the decoder SHALL emit exactly one enter pulse and then one exit pulse, each coincident with done.
REQ-030 start held high continuously, len=1: back-to-back passes with exactly one IDLE cycle between them; a second start during a pass SHALL be dropped.
REQ-031 Reset asserted in the second S_BOTH cycle (len=4): the edge that samples reset gives a=b=0 and ready=1, and no done pulse follows.
REQ-032 CAR_GEN_ABORT_EN defined, entry, len=2, abort in the first S_SECOND cycle: sequence a=0,b=1 then a=b=1 for 2 then a=1,b=0 for 2 then GAP with aborted=1 and done=0; the decoder emits no enter pulse.
